// File: rtl/noc_ext_rx.sv
// rtl/noc_ext_rx.sv - NoC external-port receive endpoint: destination filter, flit FIFO, rx/drop counters
module noc_ext_rx #(
    parameter int X           = 4,
    parameter int Y           = 4,
    parameter int data_width  = 8,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int total_width = 16,
    parameter int MY_X        = 0,
    parameter int MY_Y        = 0,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [total_width-1:0] i_flit,
    input  logic                   i_flit_valid,
    output logic                   o_flit_ready,
    output logic [data_width-1:0]  o_data,
    output logic [x_size-1:0]      o_src_x,
    output logic [y_size-1:0]      o_src_y,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [15:0]            o_rx_count,
    output logic [7:0]             o_drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = data_width + x_size + y_size;
    localparam logic [x_size-1:0] MY_XC = x_size'(MY_X);
    localparam logic [y_size-1:0] MY_YC = y_size'(MY_Y);

    if (total_width != data_width + 2 * x_size + 2 * y_size || MY_X >= X || MY_Y >= Y
        || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("noc_ext_rx: inconsistent parameters");
    end

    logic [EW-1:0]         mem_q [DEPTH];
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]           rx_cnt_q, rx_cnt_d;
    logic [7:0]            drop_cnt_q, drop_cnt_d;

    logic [data_width-1:0] f_data;
    logic [x_size-1:0]     f_src_x, f_dst_x;
    logic [y_size-1:0]     f_src_y, f_dst_y;
    logic                  full, empty, accept, match, push, pop;
    logic [EW-1:0]         head;

    // Flit layout from LSB: dst_y, dst_x, src_y, src_x, data
    assign f_dst_y = i_flit[0 +: y_size];
    assign f_dst_x = i_flit[y_size +: x_size];
    assign f_src_y = i_flit[y_size + x_size +: y_size];
    assign f_src_x = i_flit[2 * y_size + x_size +: x_size];
    assign f_data  = i_flit[total_width-1 -: data_width];

    // Status depends on registered pointers only, keeping i_ready off the o_flit_ready path
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign accept = i_flit_valid && !full;
    assign match  = (f_dst_x == MY_XC) && (f_dst_y == MY_YC);
    assign push   = accept && match;
    assign pop    = !empty && i_ready;

    assign o_flit_ready = !full;
    assign o_valid      = !empty;
    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign o_data       = head[EW-1 -: data_width];
    assign o_src_x      = head[y_size +: x_size];
    assign o_src_y      = head[0 +: y_size];
    assign o_rx_count   = rx_cnt_q;
    assign o_drop_count = drop_cnt_q;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
        rx_cnt_d   = (push && rx_cnt_q != 16'hFFFF) ? rx_cnt_q + 16'd1 : rx_cnt_q;
        drop_cnt_d = (accept && !match && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {f_data, f_src_x, f_src_y};
            end
        end
    end
endmodule

// File: tb/tb_noc_ext_rx.sv
// tb/tb_noc_ext_rx.sv - randomized queue-model bench for noc_ext_rx
`timescale 1ns/100ps
module tb_noc_ext_rx;
    localparam int MY_X  = 1;
    localparam int MY_Y  = 0;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_flit = '0;
    logic        i_flit_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_flit_ready, o_valid;
    logic [7:0]  o_data;
    logic [1:0]  o_src_x, o_src_y;
    logic [15:0] o_rx_count;
    logic [7:0]  o_drop_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] mq[$];
    int          mrx = 0;
    int          mdrop = 0;

    noc_ext_rx #(.X(4), .Y(4), .data_width(8), .x_size(2), .y_size(2), .total_width(16),
                 .MY_X(MY_X), .MY_Y(MY_Y), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_flit(i_flit), .i_flit_valid(i_flit_valid),
        .o_flit_ready(o_flit_ready), .o_data(o_data), .o_src_x(o_src_x), .o_src_y(o_src_y),
        .o_valid(o_valid), .i_ready(i_ready), .o_rx_count(o_rx_count), .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [7:0] d, input logic [1:0] sx, input logic [1:0] sy,
                                       input logic [1:0] dx, input logic [1:0] dy);
        return {d, sx, sy, dx, dy};
    endfunction

    // Reference: a queue of buffered entries; capacity and ordering come straight from the queue size
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mrx = 0;
            mdrop = 0;
        end else begin
            automatic bit was_full  = (mq.size() == DEPTH);
            automatic bit was_empty = (mq.size() == 0);
            if (!was_empty && i_ready) void'(mq.pop_front());
            if (i_flit_valid && !was_full) begin
                if (i_flit[3:2] == 2'(MY_X) && i_flit[1:0] == 2'(MY_Y)) begin
                    mq.push_back(i_flit[15:4]);
                    if (mrx < 65535) mrx++;
                end else if (mdrop < 255) begin
                    mdrop++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("o_valid", {31'd0, o_valid}, {31'd0, mq.size() != 0});
            chk("o_flit_ready", {31'd0, o_flit_ready}, {31'd0, mq.size() < DEPTH});
            chk("o_rx_count", {16'd0, o_rx_count}, mrx);
            chk("o_drop_count", {24'd0, o_drop_count}, mdrop);
            if (mq.size() != 0) chk("head", {20'd0, o_data, o_src_x, o_src_y}, {20'd0, mq[0]});
        end
    end

    task automatic drive(input logic v, input logic [15:0] f, input logic r);
        i_flit_valid = v;
        i_flit       = f;
        i_ready      = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_flit_valid = 1'b0;
        i_ready      = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        do_reset();
        chk("rst_valid", {31'd0, o_valid}, 0);
        chk("rst_ready", {31'd0, o_flit_ready}, 1);
        chk("rst_rx", {16'd0, o_rx_count}, 0);
        chk("rst_drop", {24'd0, o_drop_count}, 0);
        chk("rst_data", {24'd0, o_data}, 0);

        // Decode of 0110_1010_0001_0100: data 6A, src (0,1), dst (1,0)
        drive(1'b1, 16'b0110101000010100, 1'b0);
        chk("dec_valid", {31'd0, o_valid}, 1);
        chk("dec_data", {24'd0, o_data}, 32'h6A);
        chk("dec_sx", {30'd0, o_src_x}, 0);
        chk("dec_sy", {30'd0, o_src_y}, 1);
        chk("dec_rx", {16'd0, o_rx_count}, 1);
        drive(1'b0, 16'h0, 1'b1);
        chk("pop_valid", {31'd0, o_valid}, 0);

        // dst (0,1): misrouted
        drive(1'b1, 16'b0111000000100001, 1'b0);
        chk("mis_drop", {24'd0, o_drop_count}, 1);
        chk("mis_valid", {31'd0, o_valid}, 0);
        chk("mis_rx", {16'd0, o_rx_count}, 1);
        drive(1'b0, 16'h0, 1'b0);

        // Fill to full with the 5th flit held
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk(8'(8'h10 + i), 2'(i), 2'(3 - i), 2'd1, 2'd0), 1'b0);
            if (i == 3) chk("full_ready", {31'd0, o_flit_ready}, 0);
        end
        chk("full_rx", {16'd0, o_rx_count}, 4);
        drive(1'b1, mk(8'h14, 2'd0, 2'd3, 2'd1, 2'd0), 1'b1);
        chk("free_ready", {31'd0, o_flit_ready}, 1);
        chk("free_rx", {16'd0, o_rx_count}, 4);
        chk("free_head", {24'd0, o_data}, 32'h11);
        drive(1'b1, mk(8'h14, 2'd0, 2'd3, 2'd1, 2'd0), 1'b0);
        chk("fifth_rx", {16'd0, o_rx_count}, 5);
        for (int i = 0; i < 5; i++) drive(1'b0, 16'h0, 1'b1);
        chk("drained", {31'd0, o_valid}, 0);

        // Back-to-back streaming across pointer wrap
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, mk(8'(8'hA0 + i), 2'(i), 2'(i >> 2), 2'd1, 2'd0), 1'b1);
            chk("stream_ready", {31'd0, o_flit_ready}, 1);
        end
        chk("stream_rx", {16'd0, o_rx_count}, 12);
        drive(1'b0, 16'h0, 1'b1);

        // Drop counter saturation
        for (int i = 0; i < 260; i++) drive(1'b1, mk(8'(i), 2'd0, 2'd0, 2'd3, 2'd3), 1'b0);
        chk("drop_sat", {24'd0, o_drop_count}, 255);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            automatic logic [15:0] f = 16'($urandom);
            if ($urandom_range(0, 9) < 6) f[3:0] = {2'(MY_X), 2'(MY_Y)};
            drive($urandom_range(0, 9) < 7, f,
                  (i % 200 < 60) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1));
        end

        // Asynchronous reset between edges with data buffered
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, mk(8'(8'h30 + i), 2'd1, 2'd1, 2'd1, 2'd0), 1'b0);
        i_flit_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, o_valid}, 0);
        chk("arst_rx", {16'd0, o_rx_count}, 0);
        chk("arst_ready", {31'd0, o_flit_ready}, 1);
        #1 rst = 1'b0;
        @(negedge clk);
        drive(1'b1, mk(8'h5C, 2'd2, 2'd3, 2'd1, 2'd0), 1'b0);
        chk("post_data", {24'd0, o_data}, 32'h5C);
        chk("post_sx", {30'd0, o_src_x}, 2);
        chk("post_sy", {30'd0, o_src_y}, 3);
        chk("post_rx", {16'd0, o_rx_count}, 1);
        drive(1'b0, 16'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
